// File: rtl/event_decoder.sv
// event_decoder: detects new classifier event words, buffers them in a FIFO
// and presents them one at a time on a valid/ready output port.
// Build option: define EVENT_DECODER_FILTER_EN to drop class-0 events and
// events shorter than MIN_DURATION before they reach the FIFO.
module event_decoder #(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned MIN_DURATION = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] event_in,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic [3:0]  evt_class,
    output logic [11:0] evt_duration,
    output logic [15:0] evt_timestamp,
    output logic        overflow,
    output logic [15:0] event_count
);

    localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
    localparam int unsigned PTR_BITS = PTR_W + 1;
    localparam int unsigned CNT_W    = 16;
    localparam int unsigned DUR_W    = 12;

    typedef struct packed {
        logic [3:0]  cls;
        logic [11:0] dur;
        logic [15:0] ts;
    } evt_t;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_HOLD  = 1'b1
    } state_t;

    // Reject parameter values the pointer arithmetic and duration field cannot represent
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("event_decoder: FIFO_DEPTH must be a power of two in 2..16");
    end
    if (MIN_DURATION > 4095) begin : g_bad_min_duration
        $error("event_decoder: MIN_DURATION must fit the 12-bit duration field");
    end

    logic [31:0]         r_last_word;
    logic                r_stage_vld;
    evt_t                r_stage;
    evt_t                r_mem [FIFO_DEPTH];
    logic [PTR_BITS-1:0] r_wr_ptr;
    logic [PTR_BITS-1:0] r_rd_ptr;
    logic                r_overflow;
    logic [CNT_W-1:0]    r_count;
    state_t              r_state;
    evt_t                r_out;

    evt_t                w_word;
    logic                w_new;
    logic                w_keep;
    logic [PTR_BITS-1:0] w_level;
    logic                w_empty;
    logic                w_full;
    logic                w_has_next;
    logic                w_wr_en;
    logic                w_drop;
    state_t              w_state_nxt;
    logic                w_pop;
    logic                w_load;
    logic                w_load_next;
    logic [PTR_W-1:0]    w_rd_addr;

    assign w_word = evt_t'(event_in);
    assign w_new  = (event_in != 32'd0) && (event_in != r_last_word);

`ifdef EVENT_DECODER_FILTER_EN
    assign w_keep = w_new && (w_word.cls != 4'd0) && (w_word.dur >= DUR_W'(MIN_DURATION));
`else
    assign w_keep = w_new;
`endif

    // FIFO status; the extra pointer bit separates full from empty
    assign w_level    = r_wr_ptr - r_rd_ptr;
    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                        (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign w_has_next = (w_level > PTR_BITS'(1));

    // A pop in the same cycle frees the slot for a write into a full FIFO
    assign w_wr_en = r_stage_vld && (!w_full || w_pop);
    assign w_drop  = r_stage_vld && w_full && !w_pop;

    // The presented event stays at the FIFO head until accepted; load reads head or head+1
    assign w_rd_addr = r_rd_ptr[PTR_W-1:0] + PTR_W'(w_load_next);

    // Detection stage: remember last word and register new events
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_word <= '0;
            r_stage_vld <= 1'b0;
            r_stage     <= '0;
        end else begin
            r_last_word <= event_in;
            r_stage_vld <= w_keep;
            if (w_keep) begin
                r_stage <= w_word;
            end
        end
    end

    // FIFO storage, no reset needed since the pointers qualify every entry
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[PTR_W-1:0]] <= r_stage;
        end
    end

    // FIFO pointers, event counter and sticky overflow
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_wr_ptr   <= r_wr_ptr + PTR_BITS'(w_wr_en);
            r_rd_ptr   <= r_rd_ptr + PTR_BITS'(w_pop);
            r_count    <= r_count + CNT_W'(w_wr_en);
            r_overflow <= r_overflow | w_drop;
        end
    end

    // Output FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Output FSM next-state, pop and load decisions
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_load      = 1'b0;
        w_load_next = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (!w_empty) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (evt_ready) begin
                    w_pop = 1'b1;
                    if (w_has_next) begin
                        w_load      = 1'b1;
                        w_load_next = 1'b1;
                    end else begin
                        w_state_nxt = S_EMPTY;
                    end
                end
            end
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    // Output payload register, only changes when a new entry is loaded
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out <= '0;
        end else if (w_load) begin
            r_out <= r_mem[w_rd_addr];
        end
    end

    assign evt_valid     = (r_state == S_HOLD);
    assign evt_class     = r_out.cls;
    assign evt_duration  = r_out.dur;
    assign evt_timestamp = r_out.ts;
    assign overflow      = r_overflow;
    assign event_count   = r_count;

endmodule

// File: tb/tb_event_decoder.sv
// Scoreboard bench for event_decoder: stimulus pushes expected words into a
// queue, a negedge monitor pops and compares on every accepted transfer.
module tb_event_decoder;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned MIN_DUR = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] event_in;
    logic        evt_valid;
    logic        evt_ready;
    logic [3:0]  evt_class;
    logic [11:0] evt_duration;
    logic [15:0] evt_timestamp;
    logic        overflow;
    logic [15:0] event_count;

    event_decoder #(.FIFO_DEPTH(DEPTH), .MIN_DURATION(MIN_DUR)) dut (
        .clk          (clk),
        .rst          (rst),
        .event_in     (event_in),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_class    (evt_class),
        .evt_duration (evt_duration),
        .evt_timestamp(evt_timestamp),
        .overflow     (overflow),
        .event_count  (event_count)
    );

    always #5 clk = ~clk;

    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] prev_word;
    logic [31:0] last_nz;
    logic [15:0] exp_count;
    logic        exp_ovf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference rule: which non-zero new words reach the FIFO
    function automatic bit passes(input logic [31:0] w);
        bit ok;
        ok = (w != 32'd0);
`ifdef EVENT_DECODER_FILTER_EN
        ok = ok && (w[31:28] != 4'd0) && (int'(w[27:16]) >= int'(MIN_DUR));
`endif
        return ok;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Apply a word and update the reference: total buffering capacity is DEPTH events
    task automatic drive_nowait(input logic [31:0] w);
        event_in = w;
        if (w != 32'd0 && w != prev_word && passes(w)) begin
            if (exp_q.size() < DEPTH) begin
                exp_q.push_back(w);
                exp_count = exp_count + 16'd1;
            end else begin
                exp_ovf = 1'b1;
            end
        end
        if (w != 32'd0) last_nz = w;
        prev_word = w;
    endtask

    task automatic drive(input logic [31:0] w);
        drive_nowait(w);
        cycle();
    endtask

    task automatic wait_drain(input string name, input int bound);
        int n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            cycle();
            n++;
        end
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
        repeat (4) cycle();
    endtask

    task automatic check_status(input string name);
        check({name, "_count"}, 32'(event_count), 32'(exp_count));
        check({name, "_overflow"}, 32'(overflow), 32'(exp_ovf));
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        event_in  = 32'd0;
        prev_word = 32'd0;
        exp_q.delete();
        exp_count = 16'd0;
        exp_ovf   = 1'b0;
        repeat (2) cycle();
        rst = 1'b1;
        cycle();
    endtask

    // Guarded traffic: a new event is only offered while the reference has room
    task automatic run_traffic(input string name, input int n, input bit toggle);
        int issued = 0;
        int guard  = 0;
        logic [31:0] cand;
        int r;
        while ((issued < n || exp_q.size() != 0) && guard < 5000) begin
            guard++;
            evt_ready = toggle ? ~evt_ready : ($urandom_range(0, 2) != 0);
            if (issued >= n) begin
                cand = 32'd0;
            end else if (toggle) begin
                cand = {4'h6, 12'(issued + 2), 16'(issued * 3 + 1)};
            end else begin
                r = $urandom_range(0, 9);
                if (r < 2)       cand = 32'd0;
                else if (r == 2) cand = prev_word;
                else if (r == 3) cand = last_nz;
                else cand = {4'($urandom_range(0, 3)), 12'($urandom_range(0, 3)), 16'($urandom)};
            end
            if (cand != 32'd0 && cand != prev_word) begin
                if (exp_q.size() >= DEPTH) cand = prev_word;
                else issued++;
            end
            drive(cand);
        end
        check({name, "_finished"}, 32'(guard < 5000), 32'd1);
        evt_ready = 1'b1;
        drive(32'd0);
        repeat (4) cycle();
    endtask

    // Monitor: compare every accepted transfer and check stability while stalled
    logic        hold_prev = 1'b0;
    logic [31:0] hold_word = 32'd0;
    logic [31:0] act;
    always @(negedge clk) begin
        if (!rst) begin
            hold_prev = 1'b0;
        end else begin
            act = {evt_class, evt_duration, evt_timestamp};
            if (hold_prev) begin
                check("hold_valid", 32'(evt_valid), 32'd1);
                check("hold_stable", act, hold_word);
            end
            if (evt_valid && evt_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_event: got 0x%08h expected none", act);
                end else begin
                    check("event_order", act, exp_q.pop_front());
                end
            end
            hold_prev = evt_valid && !evt_ready;
            hold_word = act;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        evt_ready = 1'b0;
        last_nz   = 32'h1111_0001;
        do_reset();

        // Reset state
        check("rst_valid", 32'(evt_valid), 32'd0);
        check("rst_class", 32'(evt_class), 32'd0);
        check("rst_duration", 32'(evt_duration), 32'd0);
        check("rst_timestamp", 32'(evt_timestamp), 32'd0);
        check_status("rst");

        // Held word yields one event, with three-cycle latency
        evt_ready = 1'b1;
        drive_nowait(32'h1005_0123);
        repeat (3) @(negedge clk);
        check("latency_before", 32'(evt_valid), 32'd0);
        @(negedge clk);
        check("latency_at", 32'(evt_valid), 32'd1);
        check("first_payload", {evt_class, evt_duration, evt_timestamp}, 32'h1005_0123);
        @(posedge clk);
        #1;
        repeat (8) drive(32'h1005_0123);
        drive(32'd0);
        wait_drain("held", 50);
        check_status("held");

        // Same word after a zero gap is a second event
        drive(32'h2003_0001);
        drive(32'd0);
        drive(32'h2003_0001);
        drive(32'd0);
        wait_drain("regap", 50);
        check_status("regap");

        // Five consecutive events with ready low: fifth dropped
        evt_ready = 1'b0;
        for (int i = 0; i < 5; i++) drive({4'h5, 12'h003, 16'(i + 1)});
        repeat (6) drive(32'd0);
        check("full_valid", 32'(evt_valid), 32'd1);
        check("full_head", {evt_class, evt_duration, evt_timestamp}, 32'h5003_0001);
        check_status("full");
        evt_ready = 1'b1;
        wait_drain("full", 50);
        check_status("full_after");

        // Reset while events are queued
        evt_ready = 1'b0;
        drive(32'h7004_0A01);
        drive(32'h7004_0A02);
        drive(32'h7004_0A03);
        repeat (4) drive(32'd0);
        check("prerst_valid", 32'(evt_valid), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_valid", 32'(evt_valid), 32'd0);
        check("midrst_count", 32'(event_count), 32'd0);
        check("midrst_overflow", 32'(overflow), 32'd0);
        check("midrst_payload", {evt_class, evt_duration, evt_timestamp}, 32'd0);
        exp_q.delete();
        exp_count = 16'd0;
        exp_ovf   = 1'b0;
        prev_word = 32'd0;
        cycle();
        cycle();
        rst       = 1'b1;
        evt_ready = 1'b1;
        repeat (8) cycle();
        check("postrst_idle", 32'(evt_valid), 32'd0);
        drive(32'h7004_0A03);
        drive(32'd0);
        wait_drain("postrst", 50);
        check_status("postrst");

        // Ready toggling every cycle, six events
        run_traffic("toggle", 6, 1'b1);
        check_status("toggle");

        // Randomized traffic
        run_traffic("random", 300, 1'b0);
        check_status("random");

`ifdef EVENT_DECODER_FILTER_EN
        do_reset();
        evt_ready = 1'b1;
        drive(32'h0004_0010);
        drive(32'h3001_0011);
        drive(32'h3002_0012);
        drive(32'd0);
        wait_drain("filter", 50);
        check("filter_count", 32'(event_count), 32'd1);
        check_status("filter");
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
